// File: rtl/fft_stage_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the radix-2 in-place FFT stage scheduler:
//   - default FFT length, RAM address width and butterfly pipeline latency
//   - sequencer state encoding
// FFT_PIPE_LAT_DEF must equal the register depth of the butterfly datapath.
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam int unsigned FFT_N_DEF        = 64;
    localparam int unsigned FFT_AW_DEF       = 6;
    localparam int unsigned FFT_PIPE_LAT_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fft_state_e;

endpackage

// File: rtl/fft_wr_delay.sv
// -----------------------------------------------------------------------------
// fft_wr_delay
// DEPTH-deep shift register carrying {valid, k, bank} from the read issue
// point to the write-back point, with synchronous clear.
// Ports:
//   clk_i    clock, rising edge
//   clr_i    synchronous clear, empties every stage
//   valid_i  read issued this cycle
//   k_i      butterfly index of that read
//   bank_i   bank that was read
//   valid_o / k_o / bank_o   the same fields, DEPTH cycles later
// -----------------------------------------------------------------------------
module fft_wr_delay #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned KW    = 5
) (
    input  logic          clk_i,
    input  logic          clr_i,
    input  logic          valid_i,
    input  logic [KW-1:0] k_i,
    input  logic          bank_i,
    output logic          valid_o,
    output logic [KW-1:0] k_o,
    output logic          bank_o
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] bank_q;
    logic [KW-1:0]    k_q [DEPTH];

    // Shift the write-back descriptors one stage per cycle.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            valid_q <= '0;
            bank_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                k_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            bank_q[0]  <= bank_i;
            k_q[0]     <= k_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                valid_q[i] <= valid_q[i-1];
                bank_q[i]  <= bank_q[i-1];
                k_q[i]     <= k_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign bank_o  = bank_q[DEPTH-1];
    assign k_o     = k_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_scheduler.sv
// -----------------------------------------------------------------------------
// fft_stage_scheduler
// Sequences a radix-2 in-place FFT over log2(N) stages, one butterfly per
// cycle, using ping-pong RAM banks (read bank = stage[0], write bank = its
// inverse) and constant-geometry write-back.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i             one-cycle request, honoured only in IDLE
//   busy_o              high while running or draining
//   done_o              one-cycle pulse after the final write
//   stage_o             current stage index
//   rd_en_o, rd_bank_o, rd_addr_a_o, rd_addr_b_o, tf_addr_o   read side
//   wr_en_o, wr_bank_o, wr_addr_a_o, wr_addr_b_o              write side
//   result_bank_o       static bank holding the final result
// All outputs except result_bank_o come straight from flops.
// -----------------------------------------------------------------------------
module fft_stage_scheduler
    import fft_pkg::*;
#(
    parameter int unsigned N          = FFT_N_DEF,
    parameter int unsigned ADDR_WIDTH = $clog2(N),
    parameter int unsigned PIPE_LAT   = FFT_PIPE_LAT_DEF,
    localparam int unsigned SW        = $clog2(ADDR_WIDTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [SW-1:0]         stage_o,
    output logic                  rd_en_o,
    output logic                  rd_bank_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_a_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_b_o,
    output logic [ADDR_WIDTH-2:0] tf_addr_o,
    output logic                  wr_en_o,
    output logic                  wr_bank_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_a_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_b_o,
    output logic                  result_bank_o
);

    localparam int unsigned HALF = N / 2;
    localparam int unsigned KW   = ADDR_WIDTH - 1;
    localparam int unsigned DW   = $clog2(PIPE_LAT) + 1;
    localparam logic [KW-1:0] K_LAST     = KW'(HALF - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);
    localparam logic [SW-1:0] S_LAST     = SW'(ADDR_WIDTH - 1);

    // Sequencer state
    fft_state_e      state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [KW-1:0]   k_q, k_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;

    // Next values of the registered outputs
    logic                  busy_d, done_d, rd_en_d, rd_bank_d;
    logic [SW-1:0]         stage_d;
    logic [ADDR_WIDTH-1:0] rd_addr_a_d, rd_addr_b_d;
    logic [ADDR_WIDTH-2:0] tf_addr_d;
    logic [ADDR_WIDTH-1:0] k_ext_s, mask_s, hi_s;
    logic [KW-1:0]         dly_k_in_s;

    // Registered outputs
    logic                  busy_q, done_q, rd_en_q, rd_bank_q;
    logic [SW-1:0]         stage_q;
    logic [ADDR_WIDTH-1:0] rd_addr_a_q, rd_addr_b_q;
    logic [ADDR_WIDTH-2:0] tf_addr_q;
    logic                  wr_en_q, wr_bank_q;
    logic [ADDR_WIDTH-1:0] wr_addr_a_q, wr_addr_b_q;

    // Write-path delay line outputs
    logic                  dly_valid_s, dly_bank_s;
    logic [KW-1:0]         dly_k_s;

    // Sequencer state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            k_q     <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // Sequencer next-state logic: stage, butterfly index and drain counter.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            ST_IDLE: begin
                s_d    = '0;
                k_d    = '0;
                dcnt_d = '0;
                if (start_i) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (k_q == K_LAST) begin
                    state_d = ST_DRAIN;
                    dcnt_d  = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_DRAIN: begin
                // The drain gap lets the last writes of a stage land
                // before the next stage reads them.
                if (dcnt_q == DRAIN_LAST) begin
                    if (s_q == S_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                        s_d     = s_q + SW'(1);
                        k_d     = '0;
                    end
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                s_d     = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output next-values, derived from the next state so every output is a flop.
    always_comb begin
        k_ext_s   = {1'b0, k_d};
        mask_s    = ADDR_WIDTH'(HALF - 1) >> s_d;
        hi_s      = k_ext_s & ~mask_s;
        rd_en_d   = (state_d == ST_RUN);
        busy_d    = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d    = (state_d == ST_DONE);
        stage_d   = busy_d ? s_d : '0;
        rd_bank_d = busy_d & s_d[0];
        if (rd_en_d) begin
            // Insert a zero at the stride bit: low bits stay, high bits shift up.
            rd_addr_a_d = (k_ext_s & mask_s) | (hi_s << 1'b1);
            rd_addr_b_d = rd_addr_a_d + (ADDR_WIDTH'(HALF) >> s_d);
            tf_addr_d   = hi_s[ADDR_WIDTH-2:0];
            dly_k_in_s  = k_d;
        end else begin
            rd_addr_a_d = '0;
            rd_addr_b_d = '0;
            tf_addr_d   = '0;
            dly_k_in_s  = '0;
        end
    end

    // The delay line is fed with next-values, so its last stage plus the
    // write output flop together give exactly PIPE_LAT cycles of latency.
    fft_wr_delay #(
        .DEPTH (PIPE_LAT),
        .KW    (KW)
    ) u_wr_delay (
        .clk_i   (clk_i),
        .clr_i   (rst_i),
        .valid_i (rd_en_d),
        .k_i     (dly_k_in_s),
        .bank_i  (rd_bank_d),
        .valid_o (dly_valid_s),
        .k_o     (dly_k_s),
        .bank_o  (dly_bank_s)
    );

    // Output registers for both the read and write sides.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stage_q     <= '0;
            rd_en_q     <= 1'b0;
            rd_bank_q   <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            tf_addr_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_bank_q   <= 1'b0;
            wr_addr_a_q <= '0;
            wr_addr_b_q <= '0;
        end else begin
            busy_q      <= busy_d;
            done_q      <= done_d;
            stage_q     <= stage_d;
            rd_en_q     <= rd_en_d;
            rd_bank_q   <= rd_bank_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            tf_addr_q   <= tf_addr_d;
            wr_en_q     <= dly_valid_s;
            wr_bank_q   <= dly_valid_s & ~dly_bank_s;
            wr_addr_a_q <= dly_valid_s ? {1'b0, dly_k_s} : '0;
            wr_addr_b_q <= dly_valid_s ? {1'b1, dly_k_s} : '0;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign stage_o       = stage_q;
    assign rd_en_o       = rd_en_q;
    assign rd_bank_o     = rd_bank_q;
    assign rd_addr_a_o   = rd_addr_a_q;
    assign rd_addr_b_o   = rd_addr_b_q;
    assign tf_addr_o     = tf_addr_q;
    assign wr_en_o       = wr_en_q;
    assign wr_bank_o     = wr_bank_q;
    assign wr_addr_a_o   = wr_addr_a_q;
    assign wr_addr_b_o   = wr_addr_b_q;
    // An odd stage count leaves the result in bank 1.
    assign result_bank_o = ADDR_WIDTH[0];

endmodule

// File: tb/tb_fft_stage_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fft_stage_scheduler
// Directed bench: an N=8 instance for address/bank/latency/reset checks and an
// N=64 instance for back-to-back run length and strobe counts.
// -----------------------------------------------------------------------------
module tb_fft_stage_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start8 = 1'b0;
    logic start64 = 1'b0;

    always #5 clk = ~clk;

    // N=8 instance signals
    logic       busy8, done8, rd8, rdb8, wr8, wrb8, res8;
    logic [2:0] st8, ra8, rb8, wa8, wb8;
    logic [1:0] tf8;

    // N=64 instance signals
    logic       busy64, done64, rd64, rdb64, wr64, wrb64, res64;
    logic [3:0] st64;
    logic [5:0] ra64, rb64, wa64, wb64;
    logic [4:0] tf64;

    fft_stage_scheduler #(.N(8), .PIPE_LAT(3)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8),
        .busy_o(busy8), .done_o(done8), .stage_o(st8),
        .rd_en_o(rd8), .rd_bank_o(rdb8), .rd_addr_a_o(ra8), .rd_addr_b_o(rb8),
        .tf_addr_o(tf8), .wr_en_o(wr8), .wr_bank_o(wrb8),
        .wr_addr_a_o(wa8), .wr_addr_b_o(wb8), .result_bank_o(res8)
    );

    fft_stage_scheduler #(.N(64), .PIPE_LAT(3)) u_dut64 (
        .clk_i(clk), .rst_i(rst), .start_i(start64),
        .busy_o(busy64), .done_o(done64), .stage_o(st64),
        .rd_en_o(rd64), .rd_bank_o(rdb64), .rd_addr_a_o(ra64), .rd_addr_b_o(rb64),
        .tf_addr_o(tf64), .wr_en_o(wr64), .wr_bank_o(wrb64),
        .wr_addr_a_o(wa64), .wr_addr_b_o(wb64), .result_bank_o(res64)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Hand-computed N=8 read schedule: (a, b, tf) per stage, 4 butterflies each.
    int exp_a  [12] = '{0, 1, 2, 3,  0, 1, 4, 5,  0, 2, 4, 6};
    int exp_b  [12] = '{4, 5, 6, 7,  2, 3, 6, 7,  1, 3, 5, 7};
    int exp_tf [12] = '{0, 0, 0, 0,  0, 0, 2, 2,  0, 1, 2, 3};
    int exp_rbk [3] = '{0, 1, 0};
    int exp_wbk [3] = '{1, 0, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Checks one full N=8 run. Entered at the negedge of cycle t0+1, leaves
    // at the negedge of cycle t0+23. With inject set, start is pulsed in
    // cycle t0+5 (busy) and t0+22 (done), both of which must be dropped.
    task automatic run8(input bit inject);
        int st, pos;
        bit rd_exp, wr_exp;
        for (int c = 1; c <= 22; c++) begin
            st     = (c - 1) / 7;
            pos    = (c - 1) % 7;
            rd_exp = (c <= 21) && (pos < 4);
            wr_exp = (c <= 21) && (pos >= 3);
            chk($sformatf("c%0d rd_en", c), {31'd0, rd8}, {31'd0, rd_exp});
            chk($sformatf("c%0d wr_en", c), {31'd0, wr8}, {31'd0, wr_exp});
            chk($sformatf("c%0d busy", c), {31'd0, busy8}, (c <= 21) ? 32'd1 : 32'd0);
            chk($sformatf("c%0d done", c), {31'd0, done8}, (c == 22) ? 32'd1 : 32'd0);
            if (c <= 21) begin
                chk($sformatf("c%0d stage", c), {29'd0, st8}, st);
            end
            if (rd_exp) begin
                chk($sformatf("c%0d rd_a", c), {29'd0, ra8}, exp_a[st*4+pos]);
                chk($sformatf("c%0d rd_b", c), {29'd0, rb8}, exp_b[st*4+pos]);
                chk($sformatf("c%0d tf", c), {30'd0, tf8}, exp_tf[st*4+pos]);
                chk($sformatf("c%0d rd_bank", c), {31'd0, rdb8}, exp_rbk[st]);
            end
            if (wr_exp) begin
                chk($sformatf("c%0d wr_a", c), {29'd0, wa8}, pos - 3);
                chk($sformatf("c%0d wr_b", c), {29'd0, wb8}, pos + 1);
                chk($sformatf("c%0d wr_bank", c), {31'd0, wrb8}, exp_wbk[st]);
            end
            start8 = inject && (c == 5 || c == 22);
            @(negedge clk);
        end
        start8 = 1'b0;
    endtask

    // Runs the N=64 instance from its start pulse until done or a cycle
    // budget; returns the done cycle (0 on timeout) and strobe counts.
    task automatic run64(output int lat, output int nrd, output int nwr);
        lat = 0;
        nrd = 0;
        nwr = 0;
        for (int c = 1; c <= 400 && lat == 0; c++) begin
            if (done64) begin
                lat = c;
            end else begin
                if (rd64) nrd++;
                if (wr64) nwr++;
                @(negedge clk);
            end
        end
    endtask

    int lat, nrd, nwr;

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst busy8", {31'd0, busy8}, 32'd0);
        chk("rst done8", {31'd0, done8}, 32'd0);
        chk("rst rd8", {31'd0, rd8}, 32'd0);
        chk("rst wr8", {31'd0, wr8}, 32'd0);
        chk("rst stage8", {29'd0, st8}, 32'd0);
        chk("rst wr_b8", {29'd0, wb8}, 32'd0);
        chk("res8", {31'd0, res8}, 32'd1);
        chk("res64", {31'd0, res64}, 32'd0);
        chk("rst busy64", {31'd0, busy64}, 32'd0);

        // Full run with start pulses in busy and done cycles
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        run8(1'b1);
        chk("post-done idle busy", {31'd0, busy8}, 32'd0);
        chk("post-done idle rd", {31'd0, rd8}, 32'd0);

        // Start from the first IDLE cycle: new run one cycle later
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        run8(1'b0);

        // Reset during stage 1
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre-rst c9 rd", {31'd0, rd8}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid-rst busy", {31'd0, busy8}, 32'd0);
        chk("mid-rst done", {31'd0, done8}, 32'd0);
        chk("mid-rst stage", {29'd0, st8}, 32'd0);
        chk("mid-rst rd", {31'd0, rd8}, 32'd0);
        chk("mid-rst rd_bank", {31'd0, rdb8}, 32'd0);
        chk("mid-rst rd_a", {29'd0, ra8}, 32'd0);
        chk("mid-rst rd_b", {29'd0, rb8}, 32'd0);
        chk("mid-rst tf", {30'd0, tf8}, 32'd0);
        chk("mid-rst wr", {31'd0, wr8}, 32'd0);
        chk("mid-rst wr_bank", {31'd0, wrb8}, 32'd0);
        chk("mid-rst wr_a", {29'd0, wa8}, 32'd0);
        chk("mid-rst wr_b", {29'd0, wb8}, 32'd0);
        chk("mid-rst res", {31'd0, res8}, 32'd1);
        nwr = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (wr8 || rd8) nwr++;
        end
        chk("post-rst strobes", nwr, 32'd0);

        // Clean run after the abort
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        run8(1'b0);

        // N=64 back-to-back runs
        start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0;
        run64(lat, nrd, nwr);
        chk("n64 run1 latency", lat, 32'd211);
        chk("n64 run1 rd count", nrd, 32'd192);
        chk("n64 run1 wr count", nwr, 32'd192);
        chk("n64 run1 busy at done", {31'd0, busy64}, 32'd0);
        start64 = 1'b1;
        @(negedge clk);
        chk("n64 done-start dropped", {31'd0, busy64}, 32'd0);
        @(negedge clk);
        start64 = 1'b0;
        run64(lat, nrd, nwr);
        chk("n64 run2 latency", lat, 32'd211);
        chk("n64 run2 rd count", nrd, 32'd192);
        chk("n64 run2 wr count", nwr, 32'd192);
        @(negedge clk);
        chk("n64 idle after run2", {31'd0, busy64}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fft_stage_scheduler.md
# fft_stage_scheduler

Stage/address sequencer for the radix-2 in-place FFT datapath: on `start`, it drives a ping-pong pair of dual-port RAMs, the twiddle ROM and the pipelined butterfly through all log2(N) stages. It issues one butterfly per cycle. It generates the read addresses, bank select and twiddle address, and the write-back addresses delayed to match the butterfly pipeline latency. It sits between the top-level load/unload control and the RAM/butterfly/twiddle instances.

## Interface
- `N`, 64: FFT length; power of two, at least 4.
- `ADDR_WIDTH`, $clog2(N): RAM address width.
- `PIPE_LAT`, 3: cycles from a read issue to the butterfly result being ready for write; at least 1.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; accepted only in IDLE.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse after the final write.
- `stage`  out  $clog2(ADDR_WIDTH)+1  current stage index s, from 0 to ADDR_WIDTH-1.
- `rd_en`  out  1  read strobe for both ports of the read bank.
- `rd_bank`  out  1  bank being read; equals s[0].
- `rd_addr_a`, `rd_addr_b`  out  ADDR_WIDTH each  butterfly input addresses.
- `tf_addr`  out  ADDR_WIDTH-1  twiddle ROM address; valid with `rd_en`.
- `wr_en`  out  1  write strobe for both ports of the write bank.
- `wr_bank`  out  1  bank being written; the inverse of the `rd_bank` that issued the read.
- `wr_addr_a`, `wr_addr_b`  out  ADDR_WIDTH each  write-back addresses.
- `result_bank`  out  1  bank holding the final result; equals ADDR_WIDTH[0]; static.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - `start` high moves to RUN.
  - On entry to RUN: s=0, k=0.
- **RUN**
  - One butterfly per cycle with `rd_en`=1.
  - k counts from 0 to N/2-1.
  - After k=N/2-1, go to DRAIN and clear the drain counter.
- **DRAIN**
  - Lasts exactly PIPE_LAT cycles with `rd_en`=0, so stage s+1 never reads data that has not yet been written.
  - At the end of DRAIN: if s<ADDR_WIDTH-1, increment s, set k=0, return to RUN; otherwise go to DONE.
- **DONE**
  - `done`=1 for one cycle, then IDLE.
- Per-stage constants:
  - mask = (N/2-1)>>s.
  - S = (N/2)>>s.
- Read addresses:
  - `rd_addr_a` = (k & mask) | ((k & ~mask)<<1).
  - `rd_addr_b` = `rd_addr_a` + S.
- Twiddle address: `tf_addr` = (k & ~mask), truncated to ADDR_WIDTH-1 bits.
- Write addresses (constant-geometry write-back):
  - `wr_addr_a` = k.
  - `wr_addr_b` = k + N/2, i.e. MSB set.
- Write-path pipeline:
  - {valid, k, bank} is carried through a PIPE_LAT-deep shift register.
  - `wr_*` are derived from the shift register output.
- `start` is ignored while busy or in DONE.
- All arithmetic is unsigned and modulo 2^ADDR_WIDTH; no overflow can occur for legal k.

## Timing
- Reset values: every output is 0 except `result_bank`, which is constant.
  - Reset empties the write shift register.
  - Reset returns the FSM to IDLE from any state; a reset mid-FFT aborts it and no further `wr_en` is issued.
- All outputs are registered.
- Start sampled at edge t0:
  - First `rd_en` is in cycle t0+1.
  - The read issued in cycle t appears as `wr_en` in cycle t+PIPE_LAT.
- Per stage: N/2 + PIPE_LAT cycles.
- `done` is high in cycle t0+1+ADDR_WIDTH·(N/2+PIPE_LAT), immediately after the last `wr_en` cycle.
- `busy` is low in the `done` cycle.
- `start` coincident with `done` is dropped; `start` is accepted again from the first IDLE cycle.
- `wr_en` and `rd_en` never overlap on the same bank, because of the DRAIN interval.

## Structure
- Shared package `fft_pkg` holds:
  - the N and ADDR_WIDTH defaults;
  - the state encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3);
  - the PIPE_LAT default, which must match the butterfly module's register depth.
- One sub-module, `fft_wr_delay`: a parameterized PIPE_LAT-deep shift register of {valid, k, bank} with synchronous clear.

## Test plan
- **Full-run address check.** N=8, PIPE_LAT=3, start pulse; per stage, expect:
  - Stage 0: (a,b,tf) = (0,4,0) (1,5,0) (2,6,0) (3,7,0).
  - Stage 1: (a,b,tf) = (0,2,0) (1,3,0) (4,6,2) (5,7,2).
  - Stage 2: (a,b,tf) = (0,1,0) (2,3,1) (4,5,2) (6,7,3).
  - `rd_bank` = 0, 1, 0 across the three stages.
- **Write-back alignment.** Same run; expect:
  - each `wr_en` exactly 3 cycles after its `rd_en`;
  - `wr_addr` pairs (0,4) (1,5) (2,6) (3,7) in every stage;
  - `wr_bank` = 1, 0, 1 across the three stages.
- **Latency and result bank.** Start at t0 → `done` pulse at t0+22; `busy` high for cycles t0+1 to t0+21; `result_bank`=1.
- **Start ignored while busy.** Start pulses at t0+5 and in the `done` cycle → no restart. A start in the following IDLE cycle begins a new run one cycle later.
- **Reset mid-operation.** `rst` in cycle t0+9 (during stage 1) → next cycle all outputs are 0 and no `wr_en` follows. A later start produces a clean, complete 22-cycle run.
- **Back-to-back runs.** N=64, PIPE_LAT=3, two runs → each takes 6·35+1 = 211 cycles to `done`, and each run has exactly 192 `rd_en` cycles and 192 `wr_en` cycles.
